// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative 32-bit integer divider.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH  = 32;
    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned CNT_WIDTH  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) for the E stage; stalls the front
// of the pipe while busy and presents {remainder, quotient} for one cycle.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   signed_div,
    input  logic [DIV_WIDTH-1:0]   a,
    input  logic [DIV_WIDTH-1:0]   b,
    input  logic                   start,
    input  logic                   annul,
    output logic [2*DIV_WIDTH-1:0] result,
    output logic                   ready,
    output logic                   divstall
);

    div_state_t state, state_next;

    logic [DIV_WIDTH:0]   rem;
    logic [DIV_WIDTH-1:0] quo;
    logic [DIV_WIDTH-1:0] divisor;
    logic [CNT_WIDTH-1:0] count;
    logic                 sign_q;
    logic                 sign_r;

    logic [DIV_WIDTH-1:0] a_mag;
    logic [DIV_WIDTH-1:0] b_mag;
    logic [DIV_WIDTH+1:0] shifted;
    logic [DIV_WIDTH+1:0] diff;
    logic [DIV_WIDTH:0]   rem_step;
    logic [DIV_WIDTH-1:0] quo_step;
    logic [DIV_WIDTH-1:0] quo_fix;
    logic [DIV_WIDTH-1:0] rem_fix;
    logic                 last_step;
    logic                 accept;
    logic                 b_zero;

    assign a_mag  = (signed_div && a[DIV_WIDTH-1]) ? -a : a;
    assign b_mag  = (signed_div && b[DIV_WIDTH-1]) ? -b : b;
    assign b_zero = (b == '0);
    assign accept = (state == IDLE) && start && !annul;

    // The dividend register doubles as the quotient shift register: its MSB
    // feeds the remainder while the new quotient bit enters at the LSB.
    assign shifted  = {rem, quo[DIV_WIDTH-1]};
    assign diff     = shifted - {2'b00, divisor};
    assign rem_step = diff[DIV_WIDTH+1] ? shifted[DIV_WIDTH:0] : diff[DIV_WIDTH:0];
    assign quo_step = {quo[DIV_WIDTH-2:0], ~diff[DIV_WIDTH+1]};

    assign quo_fix   = sign_q ? -quo_step : quo_step;
    assign rem_fix   = sign_r ? -rem_step[DIV_WIDTH-1:0] : rem_step[DIV_WIDTH-1:0];
    assign last_step = (count == CNT_WIDTH'(DIV_CYCLES - 1));

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        divstall   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = b_zero ? DONE : BUSY;
                    divstall   = 1'b1;
                end
            end
            BUSY: begin
                divstall = !annul;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                ready      = !annul;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (annul) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            count   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            result  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (b_zero) begin
                            result <= {a, {DIV_WIDTH{1'b1}}};
                        end else begin
                            quo     <= a_mag;
                            divisor <= b_mag;
                            sign_q  <= signed_div & (a[DIV_WIDTH-1] ^ b[DIV_WIDTH-1]);
                            sign_r  <= signed_div & a[DIV_WIDTH-1];
                            rem     <= '0;
                            count   <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (!annul) begin
                        rem   <= rem_step;
                        quo   <= quo_step;
                        count <= count + 1'b1;
                        if (last_step) result <= {rem_fix, quo_fix};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit with hand-computed expectations.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        divstall;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .divstall   (divstall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves start high in the ready cycle, as the pipeline would.
    task automatic run_div(input string tag, input logic s, input logic [31:0] x,
                           input logic [31:0] y, input logic [63:0] exp, input int lat);
        int cyc = 0;
        int stalls = 0;
        signed_div = s;
        a = x;
        b = y;
        start = 1'b1;
        #1;
        while (ready !== 1'b1 && cyc < 40) begin
            if (divstall === 1'b1) stalls++;
            tick();
            cyc++;
            if (cyc == 1) begin
                a = ~x;
                b = '0;
                signed_div = ~s;
                #1;
            end
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_stalls"}, 64'(stalls), 64'(lat));
        chk({tag, "_result"}, result, exp);
        chk({tag, "_done_stall"}, 64'(divstall), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        signed_div = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_result", result, 64'd0);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_stall", 64'(divstall), 64'd0);

        run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        start = 1'b0;
        tick();
        chk("udiv_ready_once", 64'(ready), 64'd0);
        chk("udiv_hold", result, {32'd2, 32'd14});

        run_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        start = 1'b0;
        tick();
        run_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
        start = 1'b0;
        tick();
        run_div("div_zero", 1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 1);
        start = 1'b0;
        tick();
        chk("div_zero_ready_once", 64'(ready), 64'd0);
        run_div("sdiv_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        start = 1'b0;
        tick();

        // Abort in BUSY cycle 10.
        signed_div = 1'b0;
        a = 32'd1000;
        b = 32'd3;
        start = 1'b1;
        tick();
        for (int i = 1; i < 10; i++) tick();
        annul = 1'b1;
        #1;
        chk("annul_stall", 64'(divstall), 64'd0);
        chk("annul_ready", 64'(ready), 64'd0);
        tick();
        annul = 1'b0;
        start = 1'b0;
        #1;
        chk("annul_idle_stall", 64'(divstall), 64'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (ready === 1'b1) seen++;
                tick();
            end
            chk("annul_no_ready", 64'(seen), 64'd0);
        end
        chk("annul_result_kept", result, {32'd0, 32'h8000_0000});
        run_div("after_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);

        // Back-to-back: start stays high through DONE, then a new divide issues.
        start = 1'b0;
        tick();
        run_div("b2b_first", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);
        tick();
        chk("b2b_ready_once", 64'(ready), 64'd0);
        run_div("b2b_second", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33);
        start = 1'b0;
        tick();

        // Reset in BUSY cycle 20.
        signed_div = 1'b0;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        tick();
        for (int i = 1; i < 20; i++) tick();
        rst = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_result", result, 64'd0);
        chk("midrst_ready", 64'(ready), 64'd0);
        chk("midrst_stall", 64'(divstall), 64'd0);
        run_div("sdiv_m9_4", 1'b1, 32'hFFFF_FFF7, 32'd4, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 33);
        start = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 Port `signed_div` SHALL be input, 1 bit: 1 = signed divide (DIV), 0 = unsigned divide (DIVU); sampled only at start.
REQ-003 Port `a` SHALL be input, 32 bits: dividend, E-stage forwarded value, sampled only at start.
REQ-004 Port `b` SHALL be input, 32 bits: divisor, sampled only at start.
REQ-005 Port `start` SHALL be input, 1 bit: a divide instruction is in the E stage; it stays high for as long as that instruction is held in E.
REQ-006 Port `annul` SHALL be input, 1 bit: the E-stage instruction is being flushed; abort any operation.
REQ-007 Port `result` SHALL be output, 64 bits: {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-008 Port `ready` SHALL be output, 1 bit: `result` is valid this cycle.
REQ-009 Port `divstall` SHALL be output, 1 bit: hold the F/D/E stages; it feeds the hazard unit's divstall input.

Function
REQ-010 The FSM SHALL have the states IDLE, BUSY and DONE, and SHALL encode them in 2 bits.
REQ-011 In IDLE with start=1 and annul=0, the block SHALL:
- latch |a| and |b| (two's-complement magnitude when signed_div=1, raw values otherwise);
- latch sign_q = a[31]^b[31] and sign_r = a[31] (both forced to 0 when unsigned);
- clear the partial remainder and the iteration counter;
- go to BUSY.
REQ-012 BUSY SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit per cycle, MSB first.
- Partial remainder width: 33 bits.
- Iteration counter: 6 bits.
REQ-013 After the 32nd BUSY step, the block SHALL go to DONE.
- In that same transition it applies sign correction: quotient negated if sign_q, remainder negated if sign_r.
- It then registers `result`.
REQ-014 In DONE, `ready` SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally, even if start is still 1.
- This prevents the finishing instruction from restarting the divide.
REQ-015 `divstall` SHALL be combinational: (state==IDLE & start & ~annul) | (state==BUSY & ~annul); it is 0 in DONE.
REQ-016 Latency: start seen in IDLE at cycle N SHALL give ready=1 at cycle N+33, with divstall=1 on cycles N..N+32 (33 cycles).
REQ-017 Divide by zero (b==0 at start) SHALL skip BUSY and go IDLE->DONE.
- result = {a, 32'hFFFFFFFF}.
- Latency 1 cycle; divstall is high for 1 cycle.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (32-bit wrap, no trap).
REQ-019 annul=1 in any state SHALL force IDLE at the next edge.
- ready is 0 that cycle and divstall is 0 that cycle.
- `result` keeps its previous value.
- annul has priority over start.
REQ-020 `result` SHALL change only on the transition into DONE, and SHALL hold its value afterwards until the next completion.
REQ-021 In BUSY, the block SHALL ignore a, b, signed_div and start.

Reset
REQ-022 rst=1 at a clock edge SHALL set the state to IDLE, result to 0, ready to 0, and the counter and operand registers to 0.
REQ-023 rst SHALL take priority over annul and start, including mid-BUSY.
- divstall reads 0 in the cycle after reset when start=0.

Structure
REQ-024 A shared package SHALL hold the state typedef (IDLE/BUSY/DONE) and the constants DIV_WIDTH=32 and DIV_CYCLES=32.
REQ-025 The block SHALL be a single module with no sub-module.
- The shift-subtract step and the sign negation are inline combinational logic.
- Result HI/LO writeback is outside this block.

Verification
REQ-026 Unsigned divide SHALL be checked: start with signed_div=0, a=100, b=7 -> ready at +33 cycles with result={32'd2, 32'd14}, and divstall high for exactly 33 cycles.
REQ-027 Signed divide SHALL be checked: a=-7 (0xFFFFFFF9), b=2 -> quotient 0xFFFFFFFD (-3) and remainder 0xFFFFFFFF (-1); a=7, b=-2 -> quotient -3 and remainder 1.
REQ-028 Boundary values SHALL be checked:
- b=0, a=0x1234 -> ready after 1 cycle with result={0x1234, 0xFFFFFFFF};
- signed 0x80000000 / -1 -> {0, 0x80000000}.
REQ-029 Abort SHALL be checked: annul asserted at BUSY cycle 10 -> IDLE next cycle, divstall=0, ready never asserted, result unchanged.
- A new start then completes with the correct result.
REQ-030 Back-to-back and reset SHALL be checked:
- start held high through DONE -> no restart, ready for exactly 1 cycle;
- a second divide issued in the following cycle completes normally;
- rst at BUSY cycle 20 -> IDLE with result=0.
